mc_path_sequencer: RTL and testbench

//  Feeds stored price-path samples from a synchronous path SRAM into MC_CORE, one day at a time.

---
 rtl/mc_path_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mc_path_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mc_path_sequencer.sv
// Streams one day of path samples from a synchronous SRAM into MC_CORE per pass.
// Each day is sent twice; a rising core_resend either replays the day or advances to the next day.
module mc_path_sequencer #(
   parameter int DATA_W = 12,
   parameter int PATHS  = 256,
   parameter int DAYS   = 8,
   parameter int ADDR_W = 11
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      go,
   output logic                      mem_rd_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      core_start,
   output logic [DATA_W-1:0]         core_path,
   output logic                      core_vld,
   input  logic                      core_resend,
   output logic [$clog2(DAYS)-1:0]   day,
   output logic                      pass,
   output logic                      busy,
   output logic                      done
);

   localparam int IDX_W = $clog2(PATHS);
   localparam int DAY_W = $clog2(DAYS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_STREAM = 3'd2,
      S_WAIT   = 3'd3,
      S_FIN    = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [IDX_W-1:0]    r_idx;
   logic [DAY_W-1:0]    r_day;
   logic                r_pass;
   logic                r_rs_blk;
   logic                r_v1;
   logic                w_resend_evt;
   logic                w_flush;
   logic                w_last_day;
   logic                w_idx_last;
   logic [ADDR_W-1:0]   w_addr;

   // A resend counts once per rising level; r_rs_blk masks it until the line is seen low.
   assign w_resend_evt = core_resend && !r_rs_blk &&
                         ((r_state == S_STREAM) || (r_state == S_WAIT));
   assign w_flush      = w_resend_evt && (r_state == S_STREAM);
   assign w_last_day   = (r_day == DAY_W'(DAYS - 1));
   assign w_idx_last   = (r_idx == IDX_W'(PATHS - 1));
   assign w_addr       = ADDR_W'(r_day) * ADDR_W'(PATHS) + ADDR_W'(r_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (go) w_state_next = S_START;
         S_START:  w_state_next = S_STREAM;
         S_STREAM: begin
            if (w_resend_evt) begin
               w_state_next = (r_pass && w_last_day) ? S_FIN : S_STREAM;
            end else if (w_idx_last) begin
               w_state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_resend_evt) begin
               w_state_next = (r_pass && w_last_day) ? S_FIN : S_STREAM;
            end
         end
         S_FIN:    w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      mem_rd_en  = 1'b0;
      mem_addr   = '0;
      core_start = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         S_START: begin
            core_start = 1'b1;
            busy       = 1'b1;
         end
         S_STREAM: begin
            mem_rd_en = 1'b1;
            mem_addr  = w_addr;
            busy      = 1'b1;
         end
         S_WAIT:  busy = 1'b1;
         S_FIN:   done = 1'b1;
         default: ;
      endcase
   end

   assign day  = r_day;
   assign pass = r_pass;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx  <= '0;
         r_day  <= '0;
         r_pass <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (go) begin
                  r_idx  <= '0;
                  r_day  <= '0;
                  r_pass <= 1'b0;
               end
            end
            S_START: r_idx <= '0;
            S_STREAM, S_WAIT: begin
               if (w_resend_evt) begin
                  r_idx <= '0;
                  if (!r_pass) begin
                     r_pass <= 1'b1;
                  end else if (!w_last_day) begin
                     r_day  <= r_day + 1'b1;
                     r_pass <= 1'b0;
                  end
               end else if (r_state == S_STREAM) begin
                  r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rs_blk <= 1'b0;
      end else if (!core_resend) begin
         r_rs_blk <= 1'b0;
      end else if (w_resend_evt) begin
         r_rs_blk <= 1'b1;
      end
   end

   // Aborting a pass drops both in-flight samples so nothing stale reaches the core.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1      <= 1'b0;
         core_vld  <= 1'b0;
         core_path <= '0;
      end else begin
         r_v1     <= mem_rd_en && !w_flush;
         core_vld <= r_v1 && !w_flush;
         if (r_v1 && !w_flush) begin
            core_path <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mc_path_sequencer.sv
// Directed bench for mc_path_sequencer: full 16-pass run, held resend, early abort,
// go while busy and reset mid-run, against a behavioural synchronous SRAM.
module tb_mc_path_sequencer;

   localparam int DATA_W = 12;
   localparam int PATHS  = 256;
   localparam int DAYS   = 8;
   localparam int ADDR_W = 11;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              go = 1'b0;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              core_start;
   logic [DATA_W-1:0] core_path;
   logic              core_vld;
   logic              core_resend = 1'b0;
   logic [2:0]        day;
   logic              pass;
   logic              busy;
   logic              done;

   int n_vec = 0;
   int n_err = 0;

   mc_path_sequencer #(
      .DATA_W(DATA_W), .PATHS(PATHS), .DAYS(DAYS), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .go(go),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .core_start(core_start), .core_path(core_path), .core_vld(core_vld),
      .core_resend(core_resend), .day(day), .pass(pass), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic int sram_word(input int a);
      return (a * 37 + 5) & 'hFFF;
   endfunction

   // Synchronous SRAM: data for the address presented at an edge appears after that edge.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= DATA_W'(sram_word(int'(mem_addr)));
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Walk cycles k0..k1-1 of a pass; k=0 is the first address cycle.
   task automatic stream_seg(input int d, input int p, input int k0, input int k1);
      int base;
      base = d * PATHS;
      for (int k = k0; k < k1; k++) begin
         chk("day", 32'(day), d);
         chk("pass", 32'(pass), p);
         chk("busy", 32'(busy), 1);
         chk("core_start", 32'(core_start), 0);
         chk("rd_en", 32'(mem_rd_en), (k < PATHS) ? 1 : 0);
         if (k < PATHS) chk("addr", 32'(mem_addr), base + k);
         chk("vld", 32'(core_vld), (k >= 2 && k < PATHS + 2) ? 1 : 0);
         if (k >= 2 && k < PATHS + 2) chk("path", 32'(core_path), sram_word(base + k - 2));
         tick();
      end
   endtask

   task automatic pulse_resend();
      core_resend = 1'b1;
      tick();
      core_resend = 1'b0;
   endtask

   task automatic start_run();
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("start_pulse", 32'(core_start), 1);
      chk("start_busy", 32'(busy), 1);
      chk("start_day", 32'(day), 0);
      chk("start_pass", 32'(pass), 0);
      tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
      chk({tag, "_addr"}, 32'(mem_addr), 0);
      chk({tag, "_start"}, 32'(core_start), 0);
      chk({tag, "_path"}, 32'(core_path), 0);
      chk({tag, "_vld"}, 32'(core_vld), 0);
      chk({tag, "_day"}, 32'(day), 0);
      chk({tag, "_pass"}, 32'(pass), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
   endtask

   initial begin
      tick();
      tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();
      chk_all_zero("idle");

      // Full run with prompt resends: 8 days x 2 passes.
      start_run();
      for (int d = 0; d < DAYS; d++) begin
         for (int p = 0; p < 2; p++) begin
            stream_seg(d, p, 0, PATHS + 3);
            pulse_resend();
            $display("[tb] run1 day=%0d pass=%0d streamed", d, p);
         end
      end
      chk("fin_done", 32'(done), 1);
      chk("fin_busy", 32'(busy), 0);
      chk("fin_day", 32'(day), DAYS - 1);
      chk("fin_pass", 32'(pass), 1);
      tick();
      chk("idle_done", 32'(done), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_rd_en", 32'(mem_rd_en), 0);

      // Restart, then held resend (5 edges) with go asserted mid-run.
      start_run();
      stream_seg(0, 0, 0, PATHS + 3);
      core_resend = 1'b1;
      go = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      core_resend = 1'b0;
      go = 1'b0;
      stream_seg(0, 1, 4, PATHS + 3);
      $display("[tb] held resend and go-while-busy done");

      // Early resend at idx=100 of day 1 pass 0.
      pulse_resend();
      stream_seg(1, 0, 0, 100);
      pulse_resend();
      stream_seg(1, 1, 0, PATHS + 3);
      $display("[tb] early abort done");

      // Reset in the middle of day 3 streaming.
      pulse_resend();
      stream_seg(2, 0, 0, PATHS + 3);
      pulse_resend();
      stream_seg(2, 1, 0, PATHS + 3);
      pulse_resend();
      stream_seg(3, 0, 0, 50);
      rst_n = 1'b0;
      #2;
      chk_all_zero("midrst");
      tick();
      chk_all_zero("midrst_hold");
      rst_n = 1'b1;
      tick();
      start_run();
      stream_seg(0, 0, 0, 20);
      $display("[tb] reset mid-run and restart done");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
